// File: rtl/muldiv_arbiter_if.sv
// muldiv_arbiter_if
//   Connects two requester ports to a shared multiply/divide engine pair.
//   Requester side : req/op/a/b in, ack/res/err out (one set per port).
//   Engine side    : eng_op/eng_a/eng_b/eng_start out, eng_run/eng_res in.
//   Status         : busy, owner.
//   Modports:
//     slave  - the arbiter's view.
//     master - the environment's view (requesters plus engine).
interface muldiv_arbiter_if #(
    parameter int AW = 24,
    parameter int BW = 12
);
    logic          req0;
    logic          req1;
    logic          op0;
    logic          op1;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [BW-1:0] b0;
    logic [BW-1:0] b1;
    logic          ack0;
    logic          ack1;
    logic [AW-1:0] res0;
    logic [AW-1:0] res1;
    logic          err0;
    logic          err1;
    logic          eng_op;
    logic [AW-1:0] eng_a;
    logic [BW-1:0] eng_b;
    logic          eng_start;
    logic          eng_run;
    logic [AW-1:0] eng_res;
    logic          busy;
    logic          owner;

    modport slave (
        input  req0, req1, op0, op1, a0, a1, b0, b1,
        input  eng_run, eng_res,
        output ack0, ack1, res0, res1, err0, err1,
        output eng_op, eng_a, eng_b, eng_start,
        output busy, owner
    );

    modport master (
        output req0, req1, op0, op1, a0, a1, b0, b1,
        output eng_run, eng_res,
        input  ack0, ack1, res0, res1, err0, err1,
        input  eng_op, eng_a, eng_b, eng_start,
        input  busy, owner
    );
endinterface

// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter
//   Round-robin arbiter granting one of two requesters access to a shared
//   multiply/divide engine. Operands are latched at grant, the engine is
//   started with a one-cycle pulse, and its busy flag is watched with a
//   timeout. Divide-by-zero is answered directly without using the engine.
//   Ports:
//     CLK_VIDEO - only clock
//     RESET_N   - asynchronous active-low reset
//     bus       - muldiv_arbiter_if.slave (requester and engine signals)
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no operation in flight; arbitrates pending requests
//   START  | eng_start high for this single cycle
//   SETTLE | engine busy flag not yet valid; ignored for one cycle
//   WAIT   | waiting for eng_run low, counting toward the timeout
//   DONE   | ack/err/res presented for the owner; pointer updated
module muldiv_arbiter #(
    parameter int AW  = 24,
    parameter int BW  = 12,
    parameter int TMO = 63
) (
    input logic              CLK_VIDEO,
    input logic              RESET_N,
    muldiv_arbiter_if.slave  bus
);

    localparam int TW = $clog2(TMO + 1);
    // The counter is checked before it increments, so the abort fires on
    // the cycle the count would reach TMO.
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SETTLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state_q,  state_d;
    logic          owner_q,  owner_d;
    logic          last_q,   last_d;
    logic          busy_q,   busy_d;
    logic          start_q,  start_d;
    logic          ack0_q,   ack0_d;
    logic          ack1_q,   ack1_d;
    logic          err0_q,   err0_d;
    logic          err1_q,   err1_d;
    logic [AW-1:0] res0_q,   res0_d;
    logic [AW-1:0] res1_q,   res1_d;
    logic          eng_op_q, eng_op_d;
    logic [AW-1:0] eng_a_q,  eng_a_d;
    logic [BW-1:0] eng_b_q,  eng_b_d;
    logic [TW-1:0] cnt_q,    cnt_d;

    logic          gnt_port;
    logic          gnt_op;
    logic [AW-1:0] gnt_a;
    logic [BW-1:0] gnt_b;

    logic          fin;
    logic          fin_port;
    logic [AW-1:0] fin_res;
    logic          fin_err;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        eng_op_d = eng_op_q;
        eng_a_d  = eng_a_q;
        eng_b_d  = eng_b_q;
        res0_d   = res0_q;
        res1_d   = res1_q;
        start_d  = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        fin      = 1'b0;
        fin_port = owner_q;
        fin_res  = '0;
        fin_err  = 1'b0;

        // On a tie the port that was not served last wins.
        gnt_port = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
        gnt_op   = gnt_port ? bus.op1 : bus.op0;
        gnt_a    = gnt_port ? bus.a1  : bus.a0;
        gnt_b    = gnt_port ? bus.b1  : bus.b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    owner_d  = gnt_port;
                    eng_op_d = gnt_op;
                    eng_a_d  = gnt_a;
                    eng_b_d  = gnt_b;
                    if (gnt_op && (gnt_b == '0)) begin
                        state_d  = S_DONE;
                        fin      = 1'b1;
                        fin_port = gnt_port;
                        fin_res  = '1;
                        fin_err  = 1'b1;
                    end else begin
                        state_d = S_START;
                        start_d = 1'b1;
                    end
                end
            end
            S_START: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.eng_run) begin
                    state_d = S_DONE;
                    fin     = 1'b1;
                    fin_res = bus.eng_res;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_DONE;
                    fin     = 1'b1;
                    fin_res = '0;
                    fin_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_DONE: begin
                last_d  = owner_q;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The result register is loaded on entry to DONE so that res and
        // err are both valid during the ack cycle.
        if (fin) begin
            if (fin_port) begin
                ack1_d = 1'b1;
                err1_d = fin_err;
                res1_d = fin_res;
            end else begin
                ack0_d = 1'b1;
                err0_d = fin_err;
                res0_d = fin_res;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            res0_q   <= '0;
            res1_q   <= '0;
            eng_op_q <= 1'b0;
            eng_a_q  <= '0;
            eng_b_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            res0_q   <= res0_d;
            res1_q   <= res1_d;
            eng_op_q <= eng_op_d;
            eng_a_q  <= eng_a_d;
            eng_b_q  <= eng_b_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.err0      = err0_q;
    assign bus.err1      = err1_q;
    assign bus.res0      = res0_q;
    assign bus.res1      = res1_q;
    assign bus.eng_op    = eng_op_q;
    assign bus.eng_a     = eng_a_q;
    assign bus.eng_b     = eng_b_q;
    assign bus.eng_start = start_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_muldiv_arbiter.sv
module tb_muldiv_arbiter;
    localparam int AW  = 24;
    localparam int BW  = 12;
    localparam int TMO = 63;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    muldiv_arbiter_if #(.AW(AW), .BW(BW)) m ();

    muldiv_arbiter #(.AW(AW), .BW(BW), .TMO(TMO)) dut (
        .CLK_VIDEO (clk),
        .RESET_N   (rst_n),
        .bus       (m)
    );

    typedef struct {
        bit            port;
        logic [AW-1:0] res;
        bit            err;
        longint        cyc;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    longint        cyc    = 0;
    int            n_start = 0;
    logic [AW-1:0] mres [2];

    // Engine model: after a start pulse eng_run stays high through SETTLE
    // plus e_mul/e_div further cycles; eng_stuck forces it high.
    logic          eng_run_r = 1'b0;
    logic [AW-1:0] eng_res_r = '0;
    int            eng_cnt   = 0;
    int            e_mul     = 0;
    int            e_div     = 0;
    bit            eng_stuck = 1'b0;
    bit            st_s;
    logic [AW-1:0] ea, eb;

    assign m.eng_run = eng_run_r;
    assign m.eng_res = eng_res_r;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        st_s = m.eng_start;
        #1;
        if (st_s) begin
            eng_cnt = (m.eng_op ? e_div : e_mul) + 1;
            eb = AW'(m.eng_b);
            if (m.eng_op) begin
                eng_res_r = (eb == '0) ? '1 : m.eng_a / eb;
            end else begin
                ea = AW'(m.eng_a[BW-1:0]);
                eng_res_r = ea * eb;
            end
        end else if (eng_cnt > 0) begin
            eng_cnt--;
        end
        eng_run_r = eng_stuck || (eng_cnt > 0);
    end

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] model(input bit op, input logic [AW-1:0] a, input logic [BW-1:0] b);
        logic [AW-1:0] x, y;
        y = AW'(b);
        if (op) return (y == '0) ? '1 : a / y;
        x = AW'(a[BW-1:0]);
        return x * y;
    endfunction

    task automatic expect_op(input bit port, input logic [AW-1:0] res, input bit err, input longint at);
        exp_t e;
        e.port = port;
        e.res  = res;
        e.err  = err;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic drive(input bit port, input bit op, input logic [AW-1:0] a, input logic [BW-1:0] b);
        if (port) begin
            m.op1 = op; m.a1 = a; m.b1 = b; m.req1 = 1'b1;
        end else begin
            m.op0 = op; m.a0 = a; m.b0 = b; m.req0 = 1'b1;
        end
    endtask

    // Waits for 'want' acks, dropping each acked request (or, with hold,
    // keeping both high until the last ack), then checks the FSM is idle.
    task automatic serve(input int want, input bit hold, input logic [AW-1:0] a0_next, input int limit);
        int got = 0;
        int t   = 0;
        while (got < want && t < limit) begin
            @(negedge clk);
            t++;
            if (m.ack0 || m.ack1) begin
                got++;
                if (hold) begin
                    if (m.ack0) m.a0 = a0_next;
                    if (got == want) begin
                        m.req0 = 1'b0;
                        m.req1 = 1'b0;
                    end
                end else begin
                    if (m.ack0) m.req0 = 1'b0;
                    if (m.ack1) m.req1 = 1'b0;
                end
            end
        end
        chk("serve_acks", AW'(got), AW'(want));
        @(negedge clk);
        chk("idle_after_done", AW'(m.busy), '0);
    endtask

    // Scoreboard monitor.
    exp_t mon_e;
    bit   mon_p;
    always @(negedge clk) begin
        if (m.eng_start === 1'b1) n_start++;
        if (m.ack0 === 1'b1 || m.ack1 === 1'b1) begin
            chk("single_ack", AW'(m.ack0 && m.ack1), '0);
            chk("ack_expected", AW'(sb.size() != 0), AW'(1));
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                mon_p = m.ack1;
                chk("ack_port", AW'(mon_p), AW'(mon_e.port));
                chk("owner", AW'(m.owner), AW'(mon_e.port));
                chk("res", mon_p ? m.res1 : m.res0, mon_e.res);
                chk("err", AW'(mon_p ? m.err1 : m.err0), AW'(mon_e.err));
                if (mon_e.cyc >= 0) chk("ack_cycle", AW'(cyc), AW'(mon_e.cyc));
                mres[mon_p] = mon_e.res;
                chk("res_other_hold", mon_p ? m.res0 : m.res1, mres[!mon_p]);
            end
        end
    end

    longint t0;
    int     start_before;

    initial begin
        m.req0 = 1'b0; m.req1 = 1'b0;
        m.op0  = 1'b0; m.op1  = 1'b0;
        m.a0   = '0;   m.a1   = '0;
        m.b0   = '0;   m.b1   = '0;
        mres[0] = '0;  mres[1] = '0;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy",      AW'(m.busy), '0);
        chk("rst_owner",     AW'(m.owner), '0);
        chk("rst_ack0",      AW'(m.ack0), '0);
        chk("rst_ack1",      AW'(m.ack1), '0);
        chk("rst_err0",      AW'(m.err0), '0);
        chk("rst_eng_start", AW'(m.eng_start), '0);
        chk("rst_res0",      m.res0, '0);
        chk("rst_res1",      m.res1, '0);
        chk("rst_eng_a",     m.eng_a, '0);
        chk("rst_eng_b",     AW'(m.eng_b), '0);
        chk("rst_eng_op",    AW'(m.eng_op), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Tie after reset: port 0 first, then port 1
        e_mul = 2; e_div = 2;
        drive(1'b0, 1'b0, 24'd100, 12'd3);
        drive(1'b1, 1'b1, 24'd1000, 12'd7);
        t0 = cyc;
        expect_op(1'b0, model(1'b0, 24'd100, 12'd3), 1'b0, t0 + 6);
        expect_op(1'b1, model(1'b1, 24'd1000, 12'd7), 1'b0, t0 + 13);
        serve(2, 1'b0, '0, 100);

        // Single multiply, operands disturbed while busy
        e_mul = 12;
        drive(1'b0, 1'b0, 24'd720, 12'd2);
        t0 = cyc;
        expect_op(1'b0, 24'd1440, 1'b0, t0 + 16);
        repeat (3) @(negedge clk);
        m.a0 = 24'd5;
        m.b0 = 12'd9;
        serve(1, 1'b0, '0, 100);

        // Timeout with eng_run stuck high
        eng_stuck = 1'b1;
        drive(1'b0, 1'b0, 24'd7, 12'd7);
        t0 = cyc;
        expect_op(1'b0, '0, 1'b1, t0 + 3 + TMO);
        serve(1, 1'b0, '0, 200);
        eng_stuck = 1'b0;

        // Divide by zero: immediate answer, engine never started
        start_before = n_start;
        drive(1'b1, 1'b1, 24'd1080, 12'd0);
        t0 = cyc;
        expect_op(1'b1, '1, 1'b1, t0 + 1);
        serve(1, 1'b0, '0, 20);
        chk("div0_no_start", AW'(n_start - start_before), '0);

        // Normal divide on port 1
        e_div = 5;
        drive(1'b1, 1'b1, 24'd1080, 12'd7);
        t0 = cyc;
        expect_op(1'b1, 24'd154, 1'b0, t0 + 9);
        serve(1, 1'b0, '0, 100);

        // Back-to-back fairness: owners 0,1,0,1
        e_mul = 1; e_div = 3;
        drive(1'b0, 1'b0, 24'd50, 12'd4);
        drive(1'b1, 1'b1, 24'd999, 12'd3);
        t0 = cyc;
        expect_op(1'b0, model(1'b0, 24'd50, 12'd4), 1'b0, t0 + 5);
        expect_op(1'b1, model(1'b1, 24'd999, 12'd3), 1'b0, -1);
        expect_op(1'b0, model(1'b0, 24'd60, 12'd4), 1'b0, -1);
        expect_op(1'b1, model(1'b1, 24'd999, 12'd3), 1'b0, -1);
        serve(4, 1'b1, 24'd60, 300);

        // Reset in the middle of WAIT
        e_mul = 30;
        drive(1'b0, 1'b0, 24'd720, 12'd2);
        repeat (6) @(negedge clk);
        chk("busy_in_wait", AW'(m.busy), AW'(1));
        #2 rst_n = 1'b0;
        #1;
        m.req0 = 1'b0;
        mres[0] = '0;
        mres[1] = '0;
        chk("midrst_busy",  AW'(m.busy), '0);
        chk("midrst_ack0",  AW'(m.ack0), '0);
        chk("midrst_res0",  m.res0, '0);
        chk("midrst_owner", AW'(m.owner), '0);
        chk("midrst_start", AW'(m.eng_start), '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fresh request after reset, old engine activity still running
        e_mul = 2;
        drive(1'b0, 1'b0, 24'd720, 12'd2);
        t0 = cyc;
        expect_op(1'b0, 24'd1440, 1'b0, t0 + 6);
        serve(1, 1'b0, '0, 100);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", AW'(sb.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_arbiter.md
MULDIV_ARBITER -- requirements
Module: muldiv_arbiter

Interface
REQ-001 Parameter AW, 24, numerator/multiplicand width and result width.
REQ-002 Parameter BW, 12, denominator/multiplier width.
REQ-003 Parameter TMO, 63, maximum engine busy cycles before abort.
REQ-004 CLK_VIDEO  in  1  video clock; the block's only clock.
REQ-005 RESET_N  in  1  asynchronous, active-low reset.
REQ-006 req0, req1  in  1 each  requester operation request; level, held until ack.
REQ-007 op0, op1  in  1 each  requested operation: 0 = multiply, 1 = divide.
REQ-008 a0, a1  in  AW each  multiply uses a[BW-1:0] as arg1; divide uses full a as numerator.
REQ-009 b0, b1  in  BW each  multiplier or denominator.
REQ-010 ack0, ack1  out  1 each  one-cycle completion pulse.
REQ-011 res0, res1  out  AW each  per-port result register.
REQ-012 err0, err1  out  1 each  error flag; valid while the matching ack is high.
REQ-013 eng_op  out  1  operation select to the shared engine pair.
REQ-014 eng_a  out  AW  engine operand A.
REQ-015 eng_b  out  BW  engine operand B.
REQ-016 eng_start  out  1  one-cycle engine start pulse.
REQ-017 eng_run  in  1  engine busy.
REQ-018 eng_res  in  AW  engine result.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 owner  out  1  index of the port currently served; holds the last value in IDLE.

Function
REQ-021 FSM states: IDLE, START, SETTLE, WAIT, DONE.
REQ-022 IDLE, no request pending: remain in IDLE.
REQ-023 IDLE, exactly one request pending: grant that port.
REQ-024 IDLE, both requests pending: grant the port not equal to the last-served pointer (round-robin).
REQ-025 On grant, latch the granted port's op, a and b into eng_op/eng_a/eng_b and set owner.
REQ-026 Grant to divide with b == 0: go directly to DONE with result all-ones and err = 1; no eng_start.
REQ-027 All other grants: go to START.
REQ-028 START: eng_start = 1 for exactly one cycle, then go to SETTLE.
REQ-029 SETTLE: eng_run is ignored for one cycle, then go to WAIT.
REQ-030 WAIT: while eng_run = 1, increment the timeout counter.
REQ-031 WAIT, eng_run = 0: capture eng_res with err = 0 and go to DONE.
REQ-032 WAIT, timeout counter reaches TMO: go to DONE with result 0 and err = 1.
REQ-033 DONE (one cycle): write the captured result to the owner's res register.
REQ-034 DONE: pulse the owner's ack and drive its err for that cycle.
REQ-035 DONE: update the last-served pointer to owner, clear the timeout counter, return to IDLE.
REQ-036 Latency, non-zero operation: ack asserts exactly 4 + E cycles after the grant cycle, where E is the number of cycles eng_run stays high after SETTLE.
REQ-037 Divide-by-zero latency: ack asserts 1 cycle after the grant cycle.
REQ-038 res0/res1 hold their value until the next completion for the same port.
REQ-039 ack0 and ack1 are never high in the same cycle.
REQ-040 A req still high in the cycle after its ack is treated as a new request; fairness applies, so a competing pending request wins.
REQ-041 Requester operand changes while busy have no effect; operands are latched only at grant.
REQ-042 eng_a/eng_b/eng_op hold from grant through DONE.
REQ-043 A req that drops while its own operation is in flight does not cancel it; ack still pulses.

Reset
REQ-044 RESET_N low, asynchronously: FSM to IDLE.
REQ-045 RESET_N low: ack0/1, err0/1, eng_start and busy to 0.
REQ-046 RESET_N low: res0/1, eng_a, eng_b and eng_op to 0.
REQ-047 RESET_N low: owner 0; last-served pointer 1, so port 0 wins the first tie.
REQ-048 Reset mid-operation discards the operation with no ack; eng_run activity after reset is ignored until the next START.

Verification
REQ-049 Single multiply: req0, op0=0, a0=720, b0=2; engine model run 12 cycles -> ack0 on grant+16, res0=1440, err0=0.
REQ-050 Tie after reset: req0 and req1 both high in the same cycle -> port 0 served first, then port 1; one ack per DONE.
REQ-051 Divide by zero: req1, op1=1, a1=1080, b1=0 -> ack1 on grant+1, res1=all-ones, err1=1, eng_start never high.
REQ-052 Timeout: eng_run stuck high -> ack on grant+3+TMO, res=0, err=1, FSM back in IDLE.
REQ-053 Back-to-back fairness: both reqs held high for 4 operations -> owner sequence 0,1,0,1; res0 stays stable across port 1's completions.
REQ-054 Reset mid-operation: RESET_N pulsed low during WAIT -> busy=0 immediately, no ack; a fresh req0 afterwards completes normally.
